// File: rtl/debouncer_pkg.sv
// Shared types and constants for the push-button debouncer front end.
package debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } btn_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned SYNC_STAGES             = 2;

endpackage

// File: rtl/button_fsm.sv
// One button: 2-flop synchroniser, stability counter and press/release FSM.
// o_confirmed_c strobes for one cycle on the edge a press becomes confirmed.
module button_fsm
  import debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_confirmed_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that leaves IDLE/HELD counts as the first stable one,
  // so the count completes when it holds DEBOUNCE_CYCLES-1 prior samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_t             r_state;
  btn_state_t             w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_button};
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    o_confirmed_c = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_synced) begin
          if (CNT_LAST == '0) begin
            w_state_next  = ST_HELD;
            o_confirmed_c = 1'b1;
          end else begin
            w_state_next = ST_CONFIRM;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      ST_CONFIRM: begin
        if (!w_synced) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next  = ST_HELD;
          w_cnt_next    = '0;
          o_confirmed_c = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        w_cnt_next = '0;
        if (!w_synced) begin
          if (CNT_LAST == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RELEASE;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      ST_RELEASE: begin
        if (w_synced) begin
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces NB_BUTTONS push-buttons into one-hot-or-zero load pulses plus a data word.
// Define INPUT_DEBOUNCER_DATA_SNAPSHOT_EN to latch o_data with each pulse.
module input_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_BUTTONS      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_buttons,
  input  logic [NB_DATA-1:0]    i_switches,
  output logic [NB_BUTTONS-1:0] o_enable,
  output logic [NB_DATA-1:0]    o_data,
  output logic [NB_BUTTONS-1:0] o_pending
);

  logic [NB_BUTTONS-1:0]                w_confirmed;
  logic [NB_BUTTONS-1:0]                w_grant;
  logic [NB_BUTTONS-1:0]                w_pending_next;
  logic [NB_BUTTONS-1:0]                r_pending;
  logic [NB_BUTTONS-1:0]                r_enable;
  logic [SYNC_STAGES-1:0][NB_DATA-1:0] r_sw_sync;

  for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_btn
    button_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_fsm (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_button     (i_buttons[g]),
      .o_confirmed_c(w_confirmed[g])
    );
  end

  // Lowest-index pending bit wins; a fresh confirm re-sets a bit being issued.
  assign w_grant        = r_pending & (~r_pending + NB_BUTTONS'(1));
  assign w_pending_next = (r_pending & ~w_grant) | w_confirmed;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_sw_sync <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_enable  <= w_grant;
      r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], i_switches};
    end
  end

  assign o_enable  = r_enable;
  assign o_pending = r_pending;

`ifdef INPUT_DEBOUNCER_DATA_SNAPSHOT_EN
  logic [NB_DATA-1:0] r_data;

  // Capture alongside the enable so the word is valid in the pulse cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (|w_grant) begin
      r_data <= r_sw_sync[SYNC_STAGES-1];
    end
  end

  assign o_data = r_data;
`else
  assign o_data = r_sw_sync[SYNC_STAGES-1];
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with DEBOUNCE_CYCLES = 4.
module tb_input_debouncer;

  localparam int unsigned NB = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn;
  logic [DW-1:0] sw;
  logic [NB-1:0] en;
  logic [NB-1:0] pend;
  logic [DW-1:0] data;

  int n_checks;
  int n_pass;

  input_debouncer #(
    .NB_DATA        (DW),
    .NB_BUTTONS     (NB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_buttons (btn),
    .i_switches(sw),
    .o_enable  (en),
    .o_data    (data),
    .o_pending (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs reach the debouncer two edges late; a press is
  // confirmed when an armed button has been high for D consecutive samples,
  // and re-arms after D consecutive low samples. Presses queue per button.
  logic [NB-1:0] m_b_s1, m_b_s2, m_level, m_armed, m_pend, exp_en;
  logic [DW-1:0] m_sw_s1, m_sw_s2, exp_data;
  int            m_run [NB];
  logic [NB-1:0] m_synced, m_confirm, m_grant;
  logic [DW-1:0] m_old_sw;
  bit            m_found;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b_s1 = '0; m_b_s2 = '0; m_level = '0; m_armed = '1; m_pend = '0;
      exp_en = '0; m_sw_s1 = '0; m_sw_s2 = '0; exp_data = '0;
      for (int n = 0; n < NB; n++) m_run[n] = 0;
    end else begin
      m_synced = m_b_s2; m_b_s2 = m_b_s1; m_b_s1 = btn;
      m_old_sw = m_sw_s2; m_sw_s2 = m_sw_s1; m_sw_s1 = sw;
      m_confirm = '0;
      for (int n = 0; n < NB; n++) begin
        if (m_synced[n] == m_level[n]) m_run[n]++;
        else begin m_level[n] = m_synced[n]; m_run[n] = 1; end
        if (m_run[n] == int'(D)) begin
          if (m_level[n] && m_armed[n]) begin m_confirm[n] = 1'b1; m_armed[n] = 1'b0; end
          else if (!m_level[n] && !m_armed[n]) m_armed[n] = 1'b1;
        end
      end
      m_grant = '0; m_found = 1'b0;
      for (int n = 0; n < NB; n++)
        if (m_pend[n] && !m_found) begin m_grant[n] = 1'b1; m_found = 1'b1; end
      exp_en = m_grant;
      m_pend = (m_pend & ~m_grant) | m_confirm;
`ifdef INPUT_DEBOUNCER_DATA_SNAPSHOT_EN
      if (m_grant != '0) exp_data = m_old_sw;
`else
      exp_data = m_sw_s2;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0; sw = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; sw = '0;
    tick(); tick();
    n_checks++; if (en !== 3'b000) $display("FAIL reset_enable: got %b want 000", en); else n_pass++;
    n_checks++; if (pend !== 3'b000) $display("FAIL reset_pending: got %b want 000", pend); else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int first_e = -1;
    int pulses = 0;
    logic [NB-1:0] pval = '0;
    do_reset();
    btn = 3'b001;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 20) btn = '0;
      if (en != '0) begin
        pulses++;
        if (first_e < 0) begin first_e = e; pval = en; end
      end
    end
    n_checks++; if (first_e !== 7) $display("FAIL clean_latency: got edge %0d want 7", first_e); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL clean_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (pval !== 3'b001) $display("FAIL clean_value: got %b want 001", pval); else n_pass++;
  endtask

  task automatic test_bounce();
    int first_e = -1;
    int pulses = 0;
    logic [NB-1:0] pval = '0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      if (e <= 15) btn = {1'b0, ((e - 1) % 3) < 2, 1'b0};
      else if (e <= 25) btn = 3'b010;
      else btn = '0;
      tick();
      if (en != '0) begin
        pulses++;
        if (first_e < 0) begin first_e = e; pval = en; end
      end
    end
    n_checks++; if (first_e !== 22) $display("FAIL bounce_latency: got edge %0d want 22", first_e); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL bounce_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (pval !== 3'b010) $display("FAIL bounce_value: got %b want 010", pval); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] want_en [4];
    logic [NB-1:0] want_pd [4];
    want_en = '{3'b000, 3'b001, 3'b010, 3'b100};
    want_pd = '{3'b111, 3'b110, 3'b100, 3'b000};
    do_reset();
    btn = 3'b111;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e >= 6 && e <= 9) begin
        n_checks++;
        if (en !== want_en[e-6]) $display("FAIL simul_enable_e%0d: got %b want %b", e, en, want_en[e-6]);
        else n_pass++;
        n_checks++;
        if (pend !== want_pd[e-6]) $display("FAIL simul_pending_e%0d: got %b want %b", e, pend, want_pd[e-6]);
        else n_pass++;
      end
    end
    btn = '0;
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_rearm();
    int pulses = 0;
    int e1 = -1;
    int e2 = -1;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      if (e <= 10) btn = 3'b100;
      else if (e <= 12) btn = 3'b000;
      else if (e <= 22) btn = 3'b100;
      else if (e <= 28) btn = 3'b000;
      else if (e <= 38) btn = 3'b100;
      else btn = 3'b000;
      tick();
      if (en == 3'b100) begin
        pulses++;
        if (e1 < 0) e1 = e; else if (e2 < 0) e2 = e;
      end
    end
    n_checks++; if (pulses !== 2) $display("FAIL rearm_pulses: got %0d want 2", pulses); else n_pass++;
    n_checks++; if (e1 !== 7) $display("FAIL rearm_first: got edge %0d want 7", e1); else n_pass++;
    n_checks++; if (e2 !== 35) $display("FAIL rearm_second: got edge %0d want 35", e2); else n_pass++;
  endtask

  task automatic test_reset_mid_confirm();
    int first_e = -1;
    logic [NB-1:0] pval = '0;
    do_reset();
    sw = 8'hFF;
    btn = 3'b001;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    #2;
    n_checks++; if (en !== 3'b000) $display("FAIL midrst_enable: got %b want 000", en); else n_pass++;
    n_checks++; if (pend !== 3'b000) $display("FAIL midrst_pending: got %b want 000", pend); else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else n_pass++;
    tick(); tick();
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (en != '0 && first_e < 0) begin first_e = e; pval = en; end
    end
    n_checks++; if (first_e !== 7) $display("FAIL midrst_latency: got edge %0d want 7", first_e); else n_pass++;
    n_checks++; if (pval !== 3'b001) $display("FAIL midrst_value: got %b want 001", pval); else n_pass++;
    btn = '0;
  endtask

  task automatic test_data_path();
    logic [DW-1:0] want_late;
`ifdef INPUT_DEBOUNCER_DATA_SNAPSHOT_EN
    want_late = 8'hA5;
`else
    want_late = 8'h3C;
`endif
    do_reset();
    sw = 8'hA5;
    btn = 3'b001;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 10) btn = '0;
      if (e == 7) begin
        n_checks++; if (en !== 3'b001) $display("FAIL data_pulse: got %b want 001", en); else n_pass++;
        n_checks++; if (data !== 8'hA5) $display("FAIL data_at_pulse: got %h want a5", data); else n_pass++;
        sw = 8'h3C;
      end
      if (e == 8) begin
        n_checks++; if (data !== 8'hA5) $display("FAIL data_e8: got %h want a5", data); else n_pass++;
      end
      if (e == 9 || e == 15) begin
        n_checks++;
        if (data !== want_late) $display("FAIL data_e%0d: got %h want %h", e, data, want_late);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int hold [NB];
    int pulses = 0;
    do_reset();
    for (int n = 0; n < NB; n++) hold[n] = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < NB; n++) begin
        hold[n]--;
        if (hold[n] <= 0) begin
          btn[n] = ~btn[n];
          hold[n] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 14)) : int'($urandom_range(1, 4));
        end
      end
      if ($urandom_range(0, 7) == 0) sw = DW'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 799) == 0) rst = 1'b1;
      tick();
      if (en != '0) pulses++;
      n_checks++;
      if (en !== exp_en) $display("FAIL rand_enable c%0d: got %b want %b", c, en, exp_en); else n_pass++;
      n_checks++;
      if (pend !== m_pend) $display("FAIL rand_pending c%0d: got %b want %b", c, pend, m_pend); else n_pass++;
      n_checks++;
      if (data !== exp_data) $display("FAIL rand_data c%0d: got %h want %h", c, data, exp_data); else n_pass++;
      n_checks++;
      if (!$onehot0(en)) $display("FAIL rand_onehot c%0d: got %b want one-hot-or-zero", c, en); else n_pass++;
    end
    rst = 1'b0;
    n_checks++;
    if (pulses < 20) $display("FAIL rand_activity: got %0d pulses want >= 20", pulses); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; btn = '0; sw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_rearm();
    test_reset_mid_confirm();
    test_data_path();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
